znmi_arb: RTL and testbench

//  Arbiter/scheduler sharing the single NMI generator (znmi) between several
//  NMI requesters (magic button, slavespi, breakpoint logic, ...). Captures
//  per-source requests, grants one at a time round-robin, drives znmi set_nmi

---
 rtl/znmi_arb.sv | 204 ++++++++++++++++++++
 tb/tb_znmi_arb.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/znmi_arb.sv
// ----------------------------------------------------------------------------
// znmi_arb
//
// Purpose:
//   Shares the single NMI generator (znmi) between several NMI requesters.
//   Each source's request is captured on its rising edge. Pending sources are
//   granted one at a time, in round-robin order. For each grant the arbiter
//   drives set_nmi[0] as a pulse with a clean falling edge. It waits for znmi
//   to confirm entry through in_nmi, and retries if entry does not come in
//   time. After the NMI handler exits, a quiet hold-off period is enforced
//   before the next grant.
//
// Ports:
//   fclk       in   1      system clock
//   rst_n      in   1      asynchronous active-low reset
//   req        in   NSRC   request levels, a rising edge is one request
//   req_en     in   NSRC   per-source enable, 0 drops/blocks that source
//   int_start  in   1      one-cycle strobe at INT start
//   in_nmi     in   1      znmi in_nmi status
//   set_nmi    out  2      to znmi set_nmi, bit0 used, bit1 constant 0
//   gnt_id     out  IDW    id of the source currently/last granted
//   ack        out  NSRC   one-cycle pulse, granted source entered NMI
//   fail       out  1      one-cycle pulse, grant abandoned after retries
//   busy       out  1      high in every state except IDLE
// ----------------------------------------------------------------------------
module znmi_arb #(
    parameter int IDW          = 2,
    parameter int PULSE_LEN    = 2,
    parameter int TMO_INTS     = 2,
    parameter int RETRIES      = 1,
    parameter int HOLDOFF_INTS = 1
) (
    input  logic                  fclk,
    input  logic                  rst_n,
    input  logic [(1<<IDW)-1:0]   req,
    input  logic [(1<<IDW)-1:0]   req_en,
    input  logic                  int_start,
    input  logic                  in_nmi,
    output logic [1:0]            set_nmi,
    output logic [IDW-1:0]        gnt_id,
    output logic [(1<<IDW)-1:0]   ack,
    output logic                  fail,
    output logic                  busy
);

    localparam int NSRC = 1 << IDW;

    localparam logic [3:0] PULSE_LEN_C = 4'(PULSE_LEN);
    localparam logic [3:0] TMO_C       = 4'(TMO_INTS);
    localparam logic [3:0] HOLD_C      = 4'(HOLDOFF_INTS);
    localparam logic [2:0] RETRIES_C   = 3'(RETRIES);

    typedef enum logic [2:0] {
        IDLE,
        PULSE,
        WAIT,
        SERVE,
        HOLD
    } state_t;

    state_t            state;
    logic              set_q;
    logic [NSRC-1:0]   req_r;
    logic [NSRC-1:0]   pend;
    logic [IDW-1:0]    rr_ptr;
    logic [3:0]        pulse_cnt;
    logic [3:0]        int_cnt;
    logic [2:0]        tries;

    logic [NSRC-1:0]   elig;
    logic              sel_valid;
    logic [IDW-1:0]    sel_id;
    logic [IDW-1:0]    cand;
    logic [NSRC-1:0]   gnt_onehot;
    logic              entered;
    logic              tmo_hit;
    logic              give_up;
    logic [NSRC-1:0]   pend_set;
    logic [NSRC-1:0]   pend_clr;

    assign set_nmi    = {1'b0, set_q};
    assign busy       = (state != IDLE);
    assign elig       = pend & req_en;
    assign gnt_onehot = NSRC'(1) << gnt_id;

    // The WAIT-state decisions are shared by the FSM and the pending-request
    // bookkeeping, so both always see the same ack/fail outcome.
    assign entered  = (state == WAIT) && in_nmi;
    assign tmo_hit  = int_start && ((int_cnt + 4'd1) >= TMO_C);
    assign give_up  = (state == WAIT) && !in_nmi && tmo_hit && (tries >= RETRIES_C);

    // Round-robin pick: the scan runs from the farthest offset down to offset
    // zero. The candidate closest to rr_ptr is written last, so it wins.
    always_comb begin
        sel_valid = 1'b0;
        sel_id    = rr_ptr;
        cand      = rr_ptr;
        for (int k = NSRC - 1; k >= 0; k--) begin
            cand = rr_ptr + IDW'(k);
            if (elig[cand]) begin
                sel_valid = 1'b1;
                sel_id    = cand;
            end
        end
    end

    // A new edge is set in the same cycle that the grant's entry or abandonment
    // clears the bit. The set wins, so a request raised during a grant is kept.
    assign pend_set = req & ~req_r & req_en;
    assign pend_clr = ~req_en
                    | (entered ? gnt_onehot : '0)
                    | (give_up ? gnt_onehot : '0);

    // Request capture and pending bookkeeping.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            req_r <= '0;
            pend  <= '0;
        end else begin
            req_r <= req;
            pend  <= (pend & ~pend_clr) | pend_set;
        end
    end

    // Main scheduler FSM. The set_nmi pulse, ack and fail are all registered.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            set_q     <= 1'b0;
            gnt_id    <= '0;
            ack       <= '0;
            fail      <= 1'b0;
            rr_ptr    <= '0;
            pulse_cnt <= '0;
            int_cnt   <= '0;
            tries     <= '0;
        end else begin
            ack  <= '0;
            fail <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_valid && !in_nmi) begin
                        gnt_id    <= sel_id;
                        tries     <= '0;
                        set_q     <= 1'b1;
                        pulse_cnt <= 4'd1;
                        state     <= PULSE;
                    end
                end
                PULSE: begin
                    if (pulse_cnt < PULSE_LEN_C) begin
                        pulse_cnt <= pulse_cnt + 4'd1;
                    end else begin
                        set_q   <= 1'b0;
                        int_cnt <= '0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (in_nmi) begin
                        ack   <= gnt_onehot;
                        state <= SERVE;
                    end else if (tmo_hit) begin
                        int_cnt <= '0;
                        if (tries < RETRIES_C) begin
                            tries     <= tries + 3'd1;
                            set_q     <= 1'b1;
                            pulse_cnt <= 4'd1;
                            state     <= PULSE;
                        end else begin
                            fail   <= 1'b1;
                            rr_ptr <= gnt_id + IDW'(1);
                            state  <= IDLE;
                        end
                    end else if (int_start) begin
                        int_cnt <= int_cnt + 4'd1;
                    end
                end
                SERVE: begin
                    if (!in_nmi) begin
                        rr_ptr  <= gnt_id + IDW'(1);
                        int_cnt <= '0;
                        state   <= (HOLDOFF_INTS == 0) ? IDLE : HOLD;
                    end
                end
                HOLD: begin
                    if (int_start) begin
                        if ((int_cnt + 4'd1) >= HOLD_C) begin
                            int_cnt <= '0;
                            state   <= IDLE;
                        end else begin
                            int_cnt <= int_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    set_q <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_znmi_arb.sv
// ----------------------------------------------------------------------------
// tb_znmi_arb
//
// Purpose:
//   Directed self-checking bench for znmi_arb with the default parameters
//   (4 sources, 2-cycle pulse, 2-INT timeout, 1 retry, 1-INT hold-off).
//   Inputs change 1 time unit after each rising clock edge. Outputs are
//   sampled at that same point, well away from the next edge.
//
// Ports:
//   none (top-level bench)
// ----------------------------------------------------------------------------
module tb_znmi_arb;

    logic        fclk      = 1'b0;
    logic        rst_n     = 1'b0;
    logic [3:0]  req       = 4'b0000;
    logic [3:0]  req_en    = 4'b0000;
    logic        int_start = 1'b0;
    logic        in_nmi    = 1'b0;
    logic [1:0]  set_nmi;
    logic [1:0]  gnt_id;
    logic [3:0]  ack;
    logic        fail;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    znmi_arb dut (
        .fclk      (fclk),
        .rst_n     (rst_n),
        .req       (req),
        .req_en    (req_en),
        .int_start (int_start),
        .in_nmi    (in_nmi),
        .set_nmi   (set_nmi),
        .gnt_id    (gnt_id),
        .ack       (ack),
        .fail      (fail),
        .busy      (busy)
    );

    always #5 fclk = ~fclk;

    task automatic step();
        @(posedge fclk);
        #1;
    endtask

    // Drive one cycle's worth of inputs, then move just past the next edge.
    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] en,
                                 input logic is, input logic nmi);
        req       = r;
        req_en    = en;
        int_start = is;
        in_nmi    = nmi;
        step();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        req       = 4'b0000;
        req_en    = 4'b0000;
        int_start = 1'b0;
        in_nmi    = 1'b0;
        step();
        step();
        rst_n  = 1'b1;
        req_en = 4'b1111;
        step();
    endtask

    initial begin
        // Reset state
        step();
        step();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_set_nmi", 32'(set_nmi), 32'd0);
        checkOutput("rst_gnt_id", 32'(gnt_id), 32'd0);
        checkOutput("rst_ack", 32'(ack), 32'd0);
        checkOutput("rst_fail", 32'(fail), 32'd0);
        rst_n  = 1'b1;
        req_en = 4'b1111;
        step();

        // 1: single request from source 2
        $display("[TB] test 1: single request");
        applyStimulus(4'b0100, 4'hF, 1'b0, 1'b0);
        checkOutput("t1_idle_before_grant", 32'(busy), 32'd0);
        applyStimulus(4'b0100, 4'hF, 1'b0, 1'b0);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        checkOutput("t1_pulse_hi1", 32'(set_nmi), 32'd1);
        checkOutput("t1_gnt_id", 32'(gnt_id), 32'd2);
        applyStimulus(4'b0100, 4'hF, 1'b0, 1'b0);
        checkOutput("t1_pulse_hi2", 32'(set_nmi), 32'd1);
        applyStimulus(4'b0100, 4'hF, 1'b0, 1'b0);
        checkOutput("t1_pulse_lo", 32'(set_nmi), 32'd0);
        checkOutput("t1_wait_busy", 32'(busy), 32'd1);
        checkOutput("t1_no_early_ack", 32'(ack), 32'd0);
        applyStimulus(4'b0100, 4'hF, 1'b1, 1'b1);
        checkOutput("t1_ack", 32'(ack), 32'b0100);
        checkOutput("t1_ack_gnt", 32'(gnt_id), 32'd2);
        applyStimulus(4'b0000, 4'hF, 1'b0, 1'b1);
        checkOutput("t1_ack_one_cycle", 32'(ack), 32'd0);
        checkOutput("t1_serve_busy", 32'(busy), 32'd1);
        applyStimulus(4'b0000, 4'hF, 1'b0, 1'b0);
        checkOutput("t1_hold_busy", 32'(busy), 32'd1);
        applyStimulus(4'b0000, 4'hF, 1'b0, 1'b0);
        checkOutput("t1_hold_waits_int", 32'(busy), 32'd1);
        applyStimulus(4'b0000, 4'hF, 1'b1, 1'b0);
        checkOutput("t1_back_idle", 32'(busy), 32'd0);
        checkOutput("t1_gnt_kept", 32'(gnt_id), 32'd2);

        // 2: simultaneous requests 0 and 3, round-robin with wrap
        $display("[TB] test 2: round robin");
        doReset();
        applyStimulus(4'b1001, 4'hF, 1'b0, 1'b0);
        applyStimulus(4'b1001, 4'hF, 1'b0, 1'b0);
        checkOutput("t2_first_gnt", 32'(gnt_id), 32'd0);
        checkOutput("t2_first_pulse", 32'(set_nmi), 32'd1);
        applyStimulus(4'b1001, 4'hF, 1'b0, 1'b0);
        applyStimulus(4'b1001, 4'hF, 1'b0, 1'b0);
        applyStimulus(4'b1001, 4'hF, 1'b0, 1'b1);
        checkOutput("t2_ack0", 32'(ack), 32'b0001);
        applyStimulus(4'b1001, 4'hF, 1'b0, 1'b0);
        applyStimulus(4'b1001, 4'hF, 1'b1, 1'b0);
        checkOutput("t2_idle_between", 32'(busy), 32'd0);
        applyStimulus(4'b1001, 4'hF, 1'b0, 1'b0);
        checkOutput("t2_second_gnt", 32'(gnt_id), 32'd3);
        checkOutput("t2_second_pulse", 32'(set_nmi), 32'd1);
        applyStimulus(4'b1001, 4'hF, 1'b0, 1'b0);
        applyStimulus(4'b1001, 4'hF, 1'b0, 1'b0);
        applyStimulus(4'b1001, 4'hF, 1'b0, 1'b1);
        checkOutput("t2_ack3", 32'(ack), 32'b1000);
        applyStimulus(4'b1001, 4'hF, 1'b0, 1'b0);
        applyStimulus(4'b1001, 4'hF, 1'b1, 1'b0);
        applyStimulus(4'b0000, 4'hF, 1'b0, 1'b0);
        checkOutput("t2_idle_empty", 32'(busy), 32'd0);
        applyStimulus(4'b1001, 4'hF, 1'b0, 1'b0);
        applyStimulus(4'b1001, 4'hF, 1'b0, 1'b0);
        checkOutput("t2_wrapped_ptr_gnt", 32'(gnt_id), 32'd0);

        // 3: no entry ever confirmed, retry then give up
        $display("[TB] test 3: timeout and retry");
        doReset();
        applyStimulus(4'b0001, 4'hF, 1'b0, 1'b0);
        applyStimulus(4'b0001, 4'hF, 1'b0, 1'b0);
        checkOutput("t3_gnt", 32'(gnt_id), 32'd0);
        applyStimulus(4'b0001, 4'hF, 1'b0, 1'b0);
        applyStimulus(4'b0001, 4'hF, 1'b0, 1'b0);
        checkOutput("t3_wait_lo", 32'(set_nmi), 32'd0);
        applyStimulus(4'b0001, 4'hF, 1'b1, 1'b0);
        checkOutput("t3_int1_busy", 32'(busy), 32'd1);
        checkOutput("t3_int1_no_pulse", 32'(set_nmi), 32'd0);
        applyStimulus(4'b0001, 4'hF, 1'b0, 1'b0);
        applyStimulus(4'b0001, 4'hF, 1'b1, 1'b0);
        checkOutput("t3_retry_pulse", 32'(set_nmi), 32'd1);
        checkOutput("t3_retry_no_fail", 32'(fail), 32'd0);
        applyStimulus(4'b0001, 4'hF, 1'b0, 1'b0);
        applyStimulus(4'b0001, 4'hF, 1'b0, 1'b0);
        checkOutput("t3_retry_lo", 32'(set_nmi), 32'd0);
        applyStimulus(4'b0001, 4'hF, 1'b1, 1'b0);
        checkOutput("t3_int3_no_fail", 32'(fail), 32'd0);
        applyStimulus(4'b0001, 4'hF, 1'b0, 1'b0);
        applyStimulus(4'b0001, 4'hF, 1'b1, 1'b0);
        checkOutput("t3_fail", 32'(fail), 32'd1);
        checkOutput("t3_fail_idle", 32'(busy), 32'd0);
        checkOutput("t3_fail_no_ack", 32'(ack), 32'd0);
        applyStimulus(4'b0001, 4'hF, 1'b0, 1'b0);
        checkOutput("t3_fail_one_cycle", 32'(fail), 32'd0);
        checkOutput("t3_pend_cleared", 32'(busy), 32'd0);
        applyStimulus(4'b0001, 4'hF, 1'b0, 1'b0);
        checkOutput("t3_still_idle", 32'(busy), 32'd0);

        // 4: re-request during service, then disable before grant
        $display("[TB] test 4: re-request and disable");
        doReset();
        applyStimulus(4'b0010, 4'hF, 1'b0, 1'b0);
        applyStimulus(4'b0010, 4'hF, 1'b0, 1'b0);
        checkOutput("t4_gnt", 32'(gnt_id), 32'd1);
        applyStimulus(4'b0010, 4'hF, 1'b0, 1'b0);
        applyStimulus(4'b0010, 4'hF, 1'b0, 1'b0);
        applyStimulus(4'b0010, 4'hF, 1'b0, 1'b1);
        checkOutput("t4_ack", 32'(ack), 32'b0010);
        applyStimulus(4'b0000, 4'hF, 1'b0, 1'b1);
        applyStimulus(4'b0010, 4'hF, 1'b0, 1'b1);
        applyStimulus(4'b0010, 4'hF, 1'b0, 1'b0);
        applyStimulus(4'b0010, 4'hF, 1'b1, 1'b0);
        applyStimulus(4'b0010, 4'hF, 1'b0, 1'b0);
        checkOutput("t4_regrant_busy", 32'(busy), 32'd1);
        checkOutput("t4_regrant_id", 32'(gnt_id), 32'd1);
        checkOutput("t4_regrant_pulse", 32'(set_nmi), 32'd1);
        applyStimulus(4'b0010, 4'hF, 1'b0, 1'b0);
        applyStimulus(4'b0010, 4'hF, 1'b0, 1'b0);
        applyStimulus(4'b0010, 4'hF, 1'b0, 1'b1);
        checkOutput("t4_ack2", 32'(ack), 32'b0010);
        applyStimulus(4'b0000, 4'hF, 1'b0, 1'b0);
        applyStimulus(4'b0010, 4'hF, 1'b0, 1'b0);
        applyStimulus(4'b0010, 4'b1101, 1'b0, 1'b0);
        applyStimulus(4'b0010, 4'b1101, 1'b1, 1'b0);
        applyStimulus(4'b0010, 4'b1101, 1'b0, 1'b0);
        checkOutput("t4_disabled_no_gnt", 32'(busy), 32'd0);
        applyStimulus(4'b0010, 4'hF, 1'b0, 1'b0);
        applyStimulus(4'b0010, 4'hF, 1'b0, 1'b0);
        checkOutput("t4_reenable_no_gnt", 32'(busy), 32'd0);

        // 5: reset asserted in the middle of a pulse
        $display("[TB] test 5: reset mid-pulse");
        doReset();
        applyStimulus(4'b0100, 4'hF, 1'b0, 1'b0);
        applyStimulus(4'b0100, 4'hF, 1'b0, 1'b0);
        checkOutput("t5_pulse_hi", 32'(set_nmi), 32'd1);
        rst_n = 1'b0;
        req   = 4'b0000;
        #1;
        checkOutput("t5_async_set_nmi", 32'(set_nmi), 32'd0);
        checkOutput("t5_async_busy", 32'(busy), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        applyStimulus(4'b0000, 4'hF, 1'b0, 1'b0);
        applyStimulus(4'b0000, 4'hF, 1'b0, 1'b0);
        applyStimulus(4'b0000, 4'hF, 1'b0, 1'b0);
        checkOutput("t5_no_stale_grant", 32'(busy), 32'd0);
        applyStimulus(4'b0100, 4'hF, 1'b0, 1'b0);
        applyStimulus(4'b0100, 4'hF, 1'b0, 1'b0);
        checkOutput("t5_new_grant", 32'(busy), 32'd1);
        checkOutput("t5_new_gnt_id", 32'(gnt_id), 32'd2);

        // 6: external NMI in progress blocks a grant
        $display("[TB] test 6: in_nmi blocks grant");
        doReset();
        applyStimulus(4'b0001, 4'hF, 1'b0, 1'b1);
        applyStimulus(4'b0001, 4'hF, 1'b0, 1'b1);
        applyStimulus(4'b0001, 4'hF, 1'b0, 1'b1);
        checkOutput("t6_blocked", 32'(busy), 32'd0);
        checkOutput("t6_blocked_set", 32'(set_nmi), 32'd0);
        applyStimulus(4'b0001, 4'hF, 1'b0, 1'b0);
        checkOutput("t6_grant_after", 32'(busy), 32'd1);
        checkOutput("t6_gnt_id", 32'(gnt_id), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
